// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port data memory
// Optional: DMEM_ARB_FIXED_PRIO_EN gives port 0 strict priority instead of round-robin.
module dmem_arbiter #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    input  logic [2:0]        req_funct3_0,
    input  logic [2:0]        req_funct3_1,
    output logic [1:0]        rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RSP} state_t;

    localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(MEM_BYTES);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_any;
    logic              w_win;
    logic              w_hs;
    logic              w_write;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              r_last;
`endif

    // Winner selection; a lone requester wins regardless of history
    always_comb begin
        w_any = |req_valid;
        w_win = 1'b0;
        if (req_valid == 2'b10) begin
            w_win = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w_win = 1'b0;
`else
            w_win = ~r_last;
`endif
        end
    end

    assign w_addr  = w_win ? req_addr1 : req_addr0;
    assign w_write = req_write[w_win];
    assign w_err   = mem_misaligned | (w_addr >= LP_LIMIT);
    // Gating with rst_n keeps handshakes and memory enables low while reset is held
    assign w_hs    = rst_n & (r_state == S_IDLE) & w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_next = (!w_write && !w_err) ? S_RD_WAIT : S_RSP;
                end
            end
            S_RD_WAIT: w_next = S_RSP;
            S_RSP:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = w_hs ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        mem_read_en  = w_hs & ~w_write & ~w_err;
        mem_write_en = w_hs & w_write & ~w_err;
        rsp_valid    = (r_state == S_RSP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
        mem_address  = 32'(w_addr);
        mem_wdata    = w_win ? req_wdata1 : req_wdata0;
        mem_funct3   = w_win ? req_funct3_1 : req_funct3_0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_last      <= 1'b1;
`endif
        end else if (w_hs) begin
            r_owner <= w_win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_last  <= w_win;
`endif
            // Stores and errors respond next cycle, so their payload is settled now
            if (w_write || w_err) begin
                r_rsp_rdata <= 32'h0;
                r_rsp_err   <= w_err;
            end
        end else if (r_state == S_RD_WAIT) begin
            r_rsp_rdata <= mem_rdata;
            r_rsp_err   <= 1'b0;
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [2:0]  req_funct3_0, req_funct3_1, mem_funct3;
    logic [31:0] rsp_rdata, mem_address, mem_wdata, mem_rdata;
    logic        rsp_err, mem_read_en, mem_write_en, mem_misaligned;

    int n_chk = 0;
    int n_err = 0;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .mem_misaligned(mem_misaligned)
    );

    always #5 clk = ~clk;

    // Stand-in data memory: word array, byte lanes, registered formatted read
    logic [31:0] env_mem [1024];
    bit          env_init = 1'b0;

    function automatic logic [31:0] env_fmt(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'h0, s[7:0]};
            3'd5:    return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign mem_misaligned = ((mem_funct3[1:0] == 2'b01) && mem_address[0]) ||
                            ((mem_funct3[1:0] == 2'b10) && (mem_address[1:0] != 2'b00));

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= 32'h0;
            env_init <= 1'b1;
        end else begin
            if (mem_write_en) begin
                case (mem_funct3[1:0])
                    2'b00:   env_mem[mem_address[11:2]][8*mem_address[1:0] +: 8] <= mem_wdata[7:0];
                    2'b01:   env_mem[mem_address[11:2]][16*mem_address[1] +: 16] <= mem_wdata[15:0];
                    default: env_mem[mem_address[11:2]] <= mem_wdata;
                endcase
            end
            if (mem_read_en)
                mem_rdata <= env_fmt(env_mem[mem_address[11:2]], mem_address[1:0], mem_funct3);
        end
    end

    // Reference model: flat byte array and the access rules in plain arithmetic
    logic [7:0] ref_mem [MEM_BYTES];

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input logic [31:0] a, input logic [2:0] f3);
        longint la;
        la = longint'(a);
        return (la >= MEM_BYTES) || ((la % acc_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int sz;
        sz = acc_size(f3);
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        for (int i = 0; i < acc_size(f3); i++) ref_mem[a + i] = d[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f3);
        req_write[p] = wr;
        if (p == 0) begin
            req_addr0 = a; req_wdata0 = d; req_funct3_0 = f3;
        end else begin
            req_addr1 = a; req_wdata1 = d; req_funct3_1 = f3;
        end
    endtask

    // One isolated transaction with full latency and response checks
    task automatic txn(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input string tag);
        bit          e;
        int          n;
        logic [31:0] exp_d;
        logic [1:0]  pm;
        e     = ref_err(a, f3);
        exp_d = (wr || e) ? 32'h0 : ref_load(a, f3);
        pm    = (p == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        set_port(p, wr, a, d, f3);
        req_valid = pm;
        n = 0;
        @(negedge clk);
        while (req_ready != pm && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, "/ready"}, req_ready, pm);
        check({tag, "/wen"}, mem_write_en, wr && !e);
        check({tag, "/ren"}, mem_read_en, !wr && !e);
        @(posedge clk); #1;
        req_valid = 2'b00;
        if (!wr && !e) begin
            @(negedge clk);
            check({tag, "/wait_rsp"}, rsp_valid, 2'b00);
            check({tag, "/wait_en"}, {mem_read_en, mem_write_en}, 2'b00);
        end
        @(negedge clk);
        check({tag, "/rsp"}, rsp_valid, pm);
        check({tag, "/err"}, rsp_err, e);
        check({tag, "/rdata"}, rsp_rdata, exp_d);
        check({tag, "/rsp_en"}, {mem_read_en, mem_write_en}, 2'b00);
        @(negedge clk);
        check({tag, "/pulse"}, rsp_valid, 2'b00);
        if (wr && !e) ref_store(a, d, f3);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] arb_d [2][4];
        int          idx [2];
        int          rem [2];
        int          got_g [$];
        int          exp_g [8];
        int          last, g, e;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h0;
        rst_n = 1'b0;
        req_valid = 2'b00; req_write = 2'b00;
        req_addr0 = 0; req_addr1 = 0; req_wdata0 = 0; req_wdata1 = 0;
        req_funct3_0 = 0; req_funct3_1 = 0;
        repeat (3) @(negedge clk);
        check("reset/outs", {req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en}, 7'h0);
        check("reset/rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw10");
        txn(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10");
        txn(1, 1'b0, 32'h3, 32'h0, 3'd1, "lh3_mis");
        txn(0, 1'b0, 32'h1000, 32'h0, 3'd2, "lw1000");
        txn(0, 1'b1, 32'h1000, 32'h12345678, 3'd2, "sw1000");
        txn(1, 1'b1, 32'hFFC, 32'hCAFEF00D, 3'd2, "sw_top");
        txn(0, 1'b0, 32'hFFC, 32'h0, 3'd2, "lw_top");
        txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 3'd2, "lw_wrap");
        txn(0, 1'b1, 32'h21, 32'h000000A5, 3'd0, "sb21");
        txn(1, 1'b0, 32'h21, 32'h0, 3'd4, "lbu21");
        txn(1, 1'b0, 32'h21, 32'h0, 3'd0, "lb21");

        // Reset while a load sits in the read-wait state
        @(posedge clk); #1;
        set_port(0, 1'b0, 32'h10, 32'h0, 3'd2);
        req_valid = 2'b01;
        @(negedge clk);
        check("rst_mid/ready", req_ready, 2'b01);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/outs", {req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en}, 7'h0);
        check("rst_mid/rdata", rsp_rdata, 32'h0);
        req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_mid/no_rsp", rsp_valid, 2'b00);
        end

        for (int t = 0; t < 120; t++) begin
            int          p, r;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            p  = $urandom_range(0, 1);
            wr = $urandom_range(0, 1);
            if (wr) begin
                r = $urandom_range(0, 2);
                f3 = 3'(r);
            end else begin
                r = $urandom_range(0, 4);
                f3 = (r > 2) ? 3'(r + 1) : 3'(r);
            end
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 63));
            else if (r == 7) a = 32'(4092 + $urandom_range(0, 3));
            else if (r == 8) a = 32'(MEM_BYTES + $urandom_range(0, 7));
            else             a = $urandom;
            txn(p, wr, a, $urandom, f3, "rand");
        end

        // Both ports stream four word stores each
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            idx[p] = 0;
            for (int k = 0; k < 4; k++) arb_d[p][k] = $urandom;
        end
        @(posedge clk); #1;
        set_port(0, 1'b1, 32'h100, arb_d[0][0], 3'd2);
        set_port(1, 1'b1, 32'h140, arb_d[1][0], 3'd2);
        req_valid = 2'b11;
        for (int c = 0; c < 80 && got_g.size() < 8; c++) begin
            @(negedge clk);
            g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
            @(posedge clk); #1;
            if (g >= 0) begin
                got_g.push_back(g);
                ref_store(32'(32'h100 + g * 32'h40 + idx[g] * 4), arb_d[g][idx[g]], 3'd2);
                idx[g]++;
                if (idx[g] == 4) req_valid[g] = 1'b0;
                else set_port(g, 1'b1, 32'(32'h100 + g * 32'h40 + idx[g] * 4), arb_d[g][idx[g]], 3'd2);
            end
        end
        req_valid = 2'b00;
        rem[0] = 4; rem[1] = 4; last = 1;
        for (int k = 0; k < 8; k++) begin
            if (rem[0] > 0 && rem[1] > 0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                e = 0;
`else
                e = 1 - last;
`endif
            end else begin
                e = (rem[0] > 0) ? 0 : 1;
            end
            exp_g[k] = e;
            rem[e]--;
            last = e;
        end
        check("arb/count", got_g.size(), 8);
        for (int k = 0; k < got_g.size() && k < 8; k++) check("arb/order", got_g[k], exp_g[k]);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++)
                txn($urandom_range(0, 1), 1'b0, 32'(32'h100 + p * 32'h40 + k * 4), 32'h0, 3'd2, "arb_rd");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
